// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// 'product' always shows the value after the current step, so it is final while 'done' is high.
module alu_mul_iter #(
  parameter int WIDTH    = 8,
  parameter int MUL_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(STEPS + 1);

  logic [WIDTH-1:0]            mcand;
  logic [2*WIDTH-1:0]          acc;
  logic [CW-1:0]               count;
  logic [WIDTH+MUL_STEP-1:0]   partial;
  logic [WIDTH+MUL_STEP-1:0]   hi_sum;
  logic [2*WIDTH+MUL_STEP-1:0] joined;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (acc[i]) begin
        partial = partial + ({{MUL_STEP{1'b0}}, mcand} << i);
      end
    end
    hi_sum  = {{MUL_STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]} + partial;
    joined  = {hi_sum, acc[WIDTH-1:0]};
    product = joined[2*WIDTH+MUL_STEP-1:MUL_STEP];
  end

  assign done = busy && (count == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
      acc   <= '0;
      mcand <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= CW'(STEPS);
      acc   <= {{WIDTH{1'b0}}, b};
      mcand <= a;
    end else if (busy) begin
      acc   <= product;
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/add/sub, iterative full-width multiply,
// registered result and status flags. One operation in flight at a time.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  logic [1:0]         state;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;

  assign in_ready  = (state == ST_IDLE) && !mul_busy;
  assign out_valid = (state == ST_DONE);
  assign mul_start = in_valid && in_ready && (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (din1),
    .b       (din2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath; MUL and the reserved code fall through to a zero result.
  always_comb begin
    sum   = {1'b0, din1} + {1'b0, din2};
    diff  = {1'b0, din1} - {1'b0, din2};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_NOT: res = ~din1;
      OP_OR:  res = din1 | din2;
      OP_XOR: res = din1 ^ din2;
      OP_AND: res = din1 & din2;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (din1[WIDTH-1] == din2[WIDTH-1]) && (sum[WIDTH-1] != din1[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (din1[WIDTH-1] != din2[WIDTH-1]) && (diff[WIDTH-1] != din1[WIDTH-1]);
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      dout    <= '0;
      dout_hi <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            if (op == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              dout    <= res;
              dout_hi <= '0;
              flag_z  <= (res == '0);
              flag_c  <= res_c;
              flag_v  <= res_v;
              state   <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            dout    <= mul_product[WIDTH-1:0];
            dout_hi <= mul_product[2*WIDTH-1:WIDTH];
            flag_z  <= (mul_product == '0);
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: three instances (8-bit step 1, 8-bit step 2, 16-bit step 1)
// driven one operation at a time; a monitor pops expectations on each new out_valid.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  in_valid_v, out_ready_v;
  logic [2:0]  in_ready_v, out_valid_v, z_v, c_v, v_v;
  logic [2:0]  op_v   [3];
  logic [15:0] din1_v [3];
  logic [15:0] din2_v [3];
  logic [15:0] dout_v [3];
  logic [15:0] hi_v   [3];
  logic [7:0]  d0_dout, d0_hi, d1_dout, d1_hi;
  logic [15:0] d2_dout, d2_hi;

  always_comb begin
    dout_v[0] = {8'h00, d0_dout};
    hi_v[0]   = {8'h00, d0_hi};
    dout_v[1] = {8'h00, d1_dout};
    hi_v[1]   = {8'h00, d1_hi};
    dout_v[2] = d2_dout;
    hi_v[2]   = d2_hi;
  end

  alu_seq #(.WIDTH(8), .MUL_STEP(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .op(op_v[0]),
    .din1(din1_v[0][7:0]), .din2(din2_v[0][7:0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .dout(d0_dout), .dout_hi(d0_hi),
    .flag_z(z_v[0]), .flag_c(c_v[0]), .flag_v(v_v[0]));

  alu_seq #(.WIDTH(8), .MUL_STEP(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .op(op_v[1]),
    .din1(din1_v[1][7:0]), .din2(din2_v[1][7:0]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .dout(d1_dout), .dout_hi(d1_hi),
    .flag_z(z_v[1]), .flag_c(c_v[1]), .flag_v(v_v[1]));

  alu_seq #(.WIDTH(16), .MUL_STEP(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .op(op_v[2]),
    .din1(din1_v[2]), .din2(din2_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .dout(d2_dout), .dout_hi(d2_hi),
    .flag_z(z_v[2]), .flag_c(c_v[2]), .flag_v(v_v[2]));

  typedef struct {
    int          dut;
    string       name;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [2:0] seen;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Compare on each rising edge of out_valid; latency counts the accept cycle as 1.
  always @(negedge clk) begin
    if (rst) begin
      seen = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid_v[k] && !seen[k]) begin
          if (sb.size() == 0 || sb[0].dut != k) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL dut%0d unexpected result: out_valid=1, no operation outstanding", k);
          end else begin
            mon_e = sb.pop_front();
            check_output({mon_e.name, " dout"},    32'(dout_v[k]), 32'(mon_e.lo));
            check_output({mon_e.name, " dout_hi"}, 32'(hi_v[k]),   32'(mon_e.hi));
            check_output({mon_e.name, " flag_z"},  32'(z_v[k]),    32'(mon_e.z));
            check_output({mon_e.name, " flag_c"},  32'(c_v[k]),    32'(mon_e.c));
            check_output({mon_e.name, " flag_v"},  32'(v_v[k]),    32'(mon_e.v));
            check_output({mon_e.name, " latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
          end
        end
        seen[k] = out_valid_v[k];
      end
    end
  end

  task automatic apply_stimulus(input int k, input string name, input logic [2:0] o,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] lo, input logic [15:0] hi,
                                input logic z, input logic c, input logic v, input int lat);
    exp_t e;
    int budget;
    @(negedge clk);
    op_v[k]       = o;
    din1_v[k]     = a;
    din2_v[k]     = b;
    in_valid_v[k] = 1'b1;
    budget = 0;
    while (!in_ready_v[k] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready_v[k]) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s accept timeout: in_ready=0, expected 1", name);
      in_valid_v[k] = 1'b0;
      return;
    end
    e.dut = k; e.name = name; e.lo = lo; e.hi = hi;
    e.z = z; e.c = c; e.v = v; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    // Scramble operands after accept: the DUT must have sampled them already.
    in_valid_v[k] = 1'b0;
    op_v[k]       = 3'($urandom);
    din1_v[k]     = 16'($urandom);
    din2_v[k]     = 16'($urandom);
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst         = 1'b1;
    in_valid_v  = '0;
    out_ready_v = '1;
    for (int k = 0; k < 3; k++) begin
      op_v[k] = OP_NOT; din1_v[k] = '0; din2_v[k] = '0;
    end
    repeat (2) @(negedge clk);
    check_output("reset out_valid", 32'(out_valid_v[0]), 0);
    check_output("reset dout",      32'(dout_v[0]),      0);
    check_output("reset flag_z",    32'(z_v[0]),         0);
    rst = 1'b0;
    @(negedge clk);
    check_output("post-reset in_ready", 32'(in_ready_v[0]), 1);

    apply_stimulus(0, "ADD FF+01", OP_ADD, 16'hFF, 16'h01, 16'h00, 16'h0, 1'b1, 1'b1, 1'b0, 1); drain();
    apply_stimulus(0, "SUB 80-01", OP_SUB, 16'h80, 16'h01, 16'h7F, 16'h0, 1'b0, 1'b0, 1'b1, 1); drain();
    apply_stimulus(0, "ADD 7F+01", OP_ADD, 16'h7F, 16'h01, 16'h80, 16'h0, 1'b0, 1'b0, 1'b1, 1); drain();
    apply_stimulus(0, "MUL FF*FF", OP_MUL, 16'hFF, 16'hFF, 16'h01, 16'hFE, 1'b0, 1'b0, 1'b0, 9); drain();
    apply_stimulus(0, "MUL 10*10", OP_MUL, 16'h10, 16'h10, 16'h00, 16'h01, 1'b0, 1'b0, 1'b0, 9); drain();
    apply_stimulus(0, "MUL 00*5A", OP_MUL, 16'h00, 16'h5A, 16'h00, 16'h00, 1'b1, 1'b0, 1'b0, 9); drain();
    apply_stimulus(0, "OR A0|05",  OP_OR,  16'hA0, 16'h05, 16'hA5, 16'h0, 1'b0, 1'b0, 1'b0, 1); drain();
    apply_stimulus(0, "AND F0&3C", OP_AND, 16'hF0, 16'h3C, 16'h30, 16'h0, 1'b0, 1'b0, 1'b0, 1); drain();
    apply_stimulus(0, "NOT 00",    OP_NOT, 16'h00, 16'h33, 16'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1); drain();
    apply_stimulus(0, "RSV",       OP_RSV, 16'h12, 16'h34, 16'h00, 16'h0, 1'b1, 1'b0, 1'b0, 1); drain();

    // Consumer stalls: result must hold and a new request must not be taken.
    out_ready_v[0] = 1'b0;
    apply_stimulus(0, "XOR A5^5A", OP_XOR, 16'hA5, 16'h5A, 16'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1);
    in_valid_v[0] = 1'b1; op_v[0] = OP_ADD; din1_v[0] = 16'h01; din2_v[0] = 16'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall out_valid", 32'(out_valid_v[0]), 1);
      check_output("stall dout",      32'(dout_v[0]),      32'h00FF);
      check_output("stall in_ready",  32'(in_ready_v[0]),  0);
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    check_output("release in_ready",  32'(in_ready_v[0]),  1);
    check_output("release out_valid", 32'(out_valid_v[0]), 0);

    // Leave non-zero outputs, then abort a multiply with reset.
    apply_stimulus(0, "SUB 01-02", OP_SUB, 16'h01, 16'h02, 16'hFF, 16'h0, 1'b0, 1'b1, 1'b0, 1); drain();
    @(negedge clk);
    op_v[0] = OP_MUL; din1_v[0] = 16'hFF; din2_v[0] = 16'hFF; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    check_output("mul in_ready", 32'(in_ready_v[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("abort out_valid", 32'(out_valid_v[0]), 0);
    check_output("abort dout",      32'(dout_v[0]),      0);
    check_output("abort dout_hi",   32'(hi_v[0]),        0);
    check_output("abort flag_c",    32'(c_v[0]),         0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("abort in_ready", 32'(in_ready_v[0]), 1);
    apply_stimulus(0, "ADD 02+03", OP_ADD, 16'h02, 16'h03, 16'h05, 16'h0, 1'b0, 1'b0, 1'b0, 1); drain();

    apply_stimulus(1, "S2 MUL FF*FF", OP_MUL, 16'hFF, 16'hFF, 16'h01, 16'hFE, 1'b0, 1'b0, 1'b0, 5); drain();
    apply_stimulus(1, "S2 MUL 0D*0B", OP_MUL, 16'h0D, 16'h0B, 16'h8F, 16'h00, 1'b0, 1'b0, 1'b0, 5); drain();
    apply_stimulus(2, "W16 MUL FFFF*2", OP_MUL, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0001,
                   1'b0, 1'b0, 1'b0, 17); drain();
    apply_stimulus(2, "W16 ADD FFFF+1", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000,
                   1'b1, 1'b1, 1'b0, 1); drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
